// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: operation codes, FSM states
// and a small helper that classifies arithmetic operations.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // ADD and SUB go through the full adder and update carry/overflow.
  function automatic logic is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Control/serial-data bundle between the ALU and its operand/result
// shift-register environment.
interface serial_alu_if;

  logic       start;
  logic [1:0] op;
  logic       a_bit;
  logic       b_bit;
  logic       sr_en;
  logic       result_bit;
  logic       busy;
  logic       done;
  logic       flag_c;
  logic       flag_z;
  logic       flag_n;
  logic       flag_v;

  modport master (
    output start, op, a_bit, b_bit,
    input  sr_en, result_bit, busy, done, flag_c, flag_z, flag_n, flag_v
  );

  modport slave (
    input  start, op, a_bit, b_bit,
    output sr_en, result_bit, busy, done, flag_c, flag_z, flag_n, flag_v
  );

endinterface

// File: rtl/serial_fa.sv
// One-bit full adder used by the serial ADD/SUB datapath.
module serial_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: processes WIDTH-bit operands LSB first, one bit per
// clock, driving the shift enable of the surrounding operand/result
// registers and producing C/Z/N/V flags at the end of each operation.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  serial_alu_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e        state_r;
  state_e        state_nxt_s;
  op_e           op_r;
  logic [CW-1:0] cnt_r;
  logic          carry_r;
  logic          zacc_r;
  logic          flag_c_r;
  logic          flag_z_r;
  logic          flag_n_r;
  logic          flag_v_r;

  logic          run_s;
  logic          last_s;
  logic          b_eff_s;
  logic          fa_sum_s;
  logic          fa_cout_s;
  logic          res_s;
  logic          carry_nxt_s;

  assign run_s   = (state_r == RUN);
  assign last_s  = (cnt_r == LAST);
  // SUB is A + ~B + 1; the +1 comes from the carry preset at start.
  assign b_eff_s = bus.b_bit ^ (op_r == OP_SUB);

  serial_fa u_fa (
    .a    (bus.a_bit),
    .b    (b_eff_s),
    .cin  (carry_r),
    .s    (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Per-bit result and next carry for the captured operation.
  always_comb begin
    res_s       = 1'b0;
    carry_nxt_s = carry_r;
    case (op_r)
      OP_ADD, OP_SUB: begin
        res_s       = fa_sum_s;
        carry_nxt_s = fa_cout_s;
      end
      OP_AND:  res_s = bus.a_bit & bus.b_bit;
      OP_XOR:  res_s = bus.a_bit ^ bus.b_bit;
      default: res_s = 1'b0;
    endcase
  end

  // Sequencing: IDLE -> RUN for WIDTH bits -> DONE for one cycle -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_nxt_s = RUN;
        else           state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, bit counter, carry, zero accumulator and flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= IDLE;
      op_r     <= OP_ADD;
      cnt_r    <= '0;
      carry_r  <= 1'b0;
      zacc_r   <= 1'b0;
      flag_c_r <= 1'b0;
      flag_z_r <= 1'b0;
      flag_n_r <= 1'b0;
      flag_v_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            op_r    <= op_e'(bus.op);
            cnt_r   <= '0;
            carry_r <= (op_e'(bus.op) == OP_SUB);
            zacc_r  <= 1'b1;
          end
        end
        RUN: begin
          cnt_r   <= cnt_r + CW'(1);
          carry_r <= carry_nxt_s;
          zacc_r  <= zacc_r & ~res_s;
          if (last_s) begin
            // Logic operations leave the carry flag as the previous op left it.
            if (is_arith(op_r)) flag_c_r <= carry_nxt_s;
            flag_z_r <= zacc_r & ~res_s;
            flag_n_r <= res_s;
            flag_v_r <= is_arith(op_r) ? (carry_r ^ carry_nxt_s) : 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Serial result is forced low whenever no bit is being shifted.
  always_comb begin
    if (run_s) bus.result_bit = res_s;
    else       bus.result_bit = 1'b0;
  end

  assign bus.sr_en  = run_s;
  assign bus.busy   = (state_r != IDLE);
  assign bus.done   = (state_r == DONE);
  assign bus.flag_c = flag_c_r;
  assign bus.flag_z = flag_z_r;
  assign bus.flag_n = flag_n_r;
  assign bus.flag_v = flag_v_r;

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (WIDTH=8). Operands are presented
// LSB first as a right-shifting upstream register would; the result is
// reassembled from result_bit on sr_en. A word-level model gives the
// expected result and flags; a per-cycle timeline gives the expected
// handshake outputs.
module tb_serial_alu;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int checks   = 0;
  int failures = 0;

  int         cyc       = 0;
  logic [7:0] exp_res   = 8'h00;
  logic [7:0] res_cap   = 8'h00;
  logic [3:0] flags_old = 4'b0000;
  logic [3:0] flags_new = 4'b0000;

  serial_alu_if bus ();

  serial_alu #(.WIDTH(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Word-level reference: flags packed as {C, Z, N, V}.
  function automatic void model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                                input logic c_prev, output logic [7:0] r, output logic [3:0] f);
    logic [8:0] s;
    logic       c;
    logic       v;
    case (o)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      2'b01: begin
        s = {1'b0, a} + {1'b0, ~b} + 9'd1;
        r = s[7:0]; c = s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      2'b10: begin r = a & b; c = c_prev; v = 1'b0; end
      default: begin r = a ^ b; c = c_prev; v = 1'b0; end
    endcase
    f = {c, (r == 8'h00), r[7], v};
  endfunction

  // Per-cycle comparison of every output against the expected timeline.
  always @(negedge clk) begin : cmp
    logic [7:0] act;
    logic [7:0] exp;
    act = {bus.sr_en, bus.result_bit, bus.busy, bus.done,
           bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v};
    if (cyc >= 1 && cyc <= 8)  exp = {1'b1, exp_res[cyc-1], 1'b1, 1'b0, flags_old};
    else if (cyc == 9)         exp = {4'b0011, flags_new};
    else if (cyc >= 10)        exp = {4'b0000, flags_new};
    else                       exp = {4'b0000, flags_old};
    chk($sformatf("cyc%0d", cyc), {24'd0, act}, {24'd0, exp});
    if (bus.sr_en) res_cap = {bus.result_bit, res_cap[7:1]};
  end

  // Runs one operation from IDLE. poke: RUN cycle where start/op are
  // disturbed (0 = none). abort_at: RUN cycle where rstn is pulsed (0 = none).
  task automatic do_op(input string name, input logic [1:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] lit_res,
                       input logic [3:0] lit_f, input int poke, input int abort_at);
    logic [7:0] r;
    logic [3:0] f;
    model(o, a, b, flags_old[3], r, f);
    if (abort_at == 0) begin
      chk({name, "_model_res"}, {24'd0, r}, {24'd0, lit_res});
      chk({name, "_model_flags"}, {28'd0, f}, {28'd0, lit_f});
    end
    exp_res   = r;
    flags_new = f;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a_bit = a[0];
    bus.b_bit = b[0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      cyc = c;
      if (c <= 8) begin
        bus.a_bit = a[c-1];
        bus.b_bit = b[c-1];
      end else begin
        bus.a_bit = 1'b0;
        bus.b_bit = 1'b0;
      end
      if (c == poke) begin
        bus.start = 1'b1;
        bus.op    = ~o;
      end else begin
        bus.start = 1'b0;
      end
      if (c == abort_at) begin
        rstn      = 1'b0;
        cyc       = 0;
        flags_old = 4'b0000;
        #1;
        chk({name, "_rst_async"},
            {24'd0, bus.sr_en, bus.result_bit, bus.busy, bus.done,
             bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    cyc       = 0;
    flags_old = flags_new;
    chk({name, "_result"}, {24'd0, res_cap}, {24'd0, lit_res});
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a_bit = 1'b0;
    bus.b_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    do_op("add_3c_5a", 2'b00, 8'h3C, 8'h5A, 8'h96, 4'b0011, 0, 0);
    do_op("add_ff_01", 2'b00, 8'hFF, 8'h01, 8'h00, 4'b1100, 0, 0);
    do_op("sub_10_10", 2'b01, 8'h10, 8'h10, 8'h00, 4'b1100, 0, 0);
    do_op("sub_00_01", 2'b01, 8'h00, 8'h01, 8'hFF, 4'b0010, 0, 0);
    do_op("and_f0_3c", 2'b10, 8'hF0, 8'h3C, 8'h30, 4'b0000, 0, 0);
    do_op("xor_f0_3c", 2'b11, 8'hF0, 8'h3C, 8'hCC, 4'b0010, 0, 0);
    do_op("add_poke",  2'b00, 8'h3C, 8'h5A, 8'h96, 4'b0011, 4, 0);
    do_op("sub_abort", 2'b01, 8'h10, 8'h10, 8'h00, 4'b1100, 0, 3);
    do_op("add_after", 2'b00, 8'hFF, 8'h01, 8'h00, 4'b1100, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
